// File: rtl/cpu_pkg.sv
// Shared definitions for the parametrised accumulator core: opcodes and sequencer states.
package cpu_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_XOR = 3'b010;
  localparam logic [OP_W-1:0] OP_SHL = 3'b011;
  localparam logic [OP_W-1:0] OP_LDA = 3'b100;
  localparam logic [OP_W-1:0] OP_STA = 3'b101;
  localparam logic [OP_W-1:0] OP_CMA = 3'b110;
  localparam logic [OP_W-1:0] OP_HLT = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_EX0, S_EX1
  } state_t;

  // Register ops finish in T3 and never touch memory operands.
  function automatic logic is_reg_op(input logic [OP_W-1:0] op);
    return (op == OP_SHL) || (op == OP_CMA) || (op == OP_HLT);
  endfunction

endpackage

// File: rtl/cpu_mem.sv
// Private program/data memory: sync-read/write CPU port, host write port, async host read port.
module cpu_mem #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] ld_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Array writes; the CPU and host ports are never active in the same cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (ld_we) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // Registered read of the CPU port, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else begin
      rdata <= mem[addr];
    end
  end

  assign ld_rdata = mem[ld_addr];

endmodule

// File: rtl/cpu_core_param.sv
// Parametrised accumulator CPU core with fetch/decode/indirect/execute sequencer.
// Optional feature macro: CPU_INDIRECT_EN (honours the I bit via the T4/T5 path).
module cpu_core_param
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ac,
  output logic              e,
  output logic              zero
);

  state_t            state;
  logic [ADDR_W-1:0] ar;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] rdata;
  logic [OP_W-1:0]   op;
  logic [ADDR_W-1:0] addr_f;
  logic [DATA_W-1:0] addend;
  logic [DATA_W:0]   sum;
  logic              mem_we;
  logic              host_we;
  logic              unused_bits;

  assign op          = ir[DATA_W-2 -: OP_W];
  assign addr_f      = ir[ADDR_W-1:0];
  assign unused_bits = &{1'b0, ir};

  // SHL is AC+AC, ADD is AC+M; both share one adder with carry-out.
  assign addend  = (op == OP_SHL) ? ac : rdata;
  assign sum     = {1'b0, ac} + {1'b0, addend};
  assign mem_we  = (state == S_EX0) && (op == OP_STA);
  assign host_we = ld_we && (state == S_IDLE);
  assign zero    = (ac == '0);

  // Sequencer with all architectural registers; reset aborts any instruction in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= S_IDLE;
      halted <= 1'b1;
      pc     <= '0;
      ar     <= '0;
      ir     <= '0;
      ac     <= '0;
      e      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_T0;
            halted <= 1'b0;
          end
        end
        S_T0: begin
          ar    <= pc;
          state <= S_T1;
        end
        S_T1: state <= S_T2;
        S_T2: begin
          ir    <= rdata;
          pc    <= pc + ADDR_W'(1);
          state <= S_T3;
        end
        S_T3: begin
          if (is_reg_op(op)) begin
            state <= S_T0;
            case (op)
              OP_SHL:  {e, ac} <= sum;
              OP_CMA:  ac <= ~ac;
              default: begin
                state  <= S_IDLE;
                halted <= 1'b1;
              end
            endcase
          end else begin
            ar <= addr_f;
`ifdef CPU_INDIRECT_EN
            state <= ir[DATA_W-1] ? S_T4 : S_EX0;
`else
            state <= S_EX0;
`endif
          end
        end
`ifdef CPU_INDIRECT_EN
        S_T4: state <= S_T5;
        S_T5: begin
          ar    <= rdata[ADDR_W-1:0];
          state <= S_EX0;
        end
`endif
        S_EX0: state <= (op == OP_STA) ? S_T0 : S_EX1;
        S_EX1: begin
          state <= S_T0;
          case (op)
            OP_ADD: {e, ac} <= sum;
            OP_SUB: begin
              ac <= ac - rdata;
              e  <= (ac >= rdata);
            end
            OP_XOR:  ac <= ac ^ rdata;
            default: ac <= rdata;
          endcase
        end
        default: begin
          state  <= S_IDLE;
          halted <= 1'b1;
        end
      endcase
    end
  end

  cpu_mem #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem (
    .clk     (CLK),
    .rst     (RST),
    .we      (mem_we),
    .addr    (ar),
    .wdata   (ac),
    .rdata   (rdata),
    .ld_we   (host_we),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .ld_rdata(ld_rdata)
  );

endmodule

// File: tb/tb_cpu_core_param.sv
// Bench for cpu_core_param: instruction-level reference model, per-cycle compare, directed and random programs.
module tb_cpu_core_param;

  localparam int unsigned AW   = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned MAXC = 1024;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic          ld_we = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic [DW-1:0] ld_rdata;
  logic          halted;
  logic [AW-1:0] pc;
  logic [DW-1:0] ac;
  logic          e;
  logic          zero;

  cpu_core_param #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .start   (start),
    .ld_we   (ld_we),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .ld_rdata(ld_rdata),
    .halted  (halted),
    .pc      (pc),
    .ac      (ac),
    .e       (e),
    .zero    (zero)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    else n_pass++;
  endtask

  // Reference model: architectural state plus per-cycle expected outputs.
  logic [7:0] mm [16];
  logic [3:0] m_pc = '0;
  logic [7:0] m_ac = '0;
  logic       m_e  = 1'b0;
  bit         m_done;
  logic [3:0] x_pc [MAXC];
  logic [7:0] x_ac [MAXC];
  logic       x_e  [MAXC];
  logic       x_h  [MAXC];
  int         exp_n = 0;
  int         cyc = 0;
  bit         cmp_on = 1'b0;

  task automatic model_run(input int max_instr);
    logic [7:0] w, opd, ac0;
    logic [3:0] ea, pc0;
    logic       e0;
    logic [8:0] s;
    int         t, len;
    t = 0;
    m_done = 1'b0;
    for (int n = 0; n < max_instr && !m_done; n++) begin
      w = mm[m_pc];
      pc0 = m_pc; ac0 = m_ac; e0 = m_e;
      m_pc = m_pc + 4'd1;
      ea = w[3:0];
      len = 6;
`ifdef CPU_INDIRECT_EN
      if (w[7]) begin
        ea = mm[w[3:0]][3:0];
        len = 8;
      end
`endif
      opd = mm[ea];
      case (w[6:4])
        3'd0: begin s = {1'b0, m_ac} + {1'b0, opd}; m_ac = s[7:0]; m_e = s[8]; end
        3'd1: begin m_e = (m_ac >= opd); m_ac = m_ac - opd; end
        3'd2: m_ac = m_ac ^ opd;
        3'd3: begin s = {1'b0, m_ac} + {1'b0, m_ac}; m_ac = s[7:0]; m_e = s[8]; len = 4; end
        3'd4: m_ac = opd;
        3'd5: begin mm[ea] = m_ac; len = len - 1; end
        3'd6: begin m_ac = ~m_ac; len = 4; end
        default: begin m_done = 1'b1; len = 4; end
      endcase
      for (int c = 0; c < len; c++) begin
        x_pc[t+c] = (c < 3) ? pc0 : m_pc;
        x_ac[t+c] = ac0;
        x_e[t+c]  = e0;
        x_h[t+c]  = 1'b0;
      end
      t += len;
    end
    if (m_done) begin
      x_pc[t] = m_pc; x_ac[t] = m_ac; x_e[t] = m_e; x_h[t] = 1'b1;
      t++;
    end
    exp_n = t;
  endtask

  // Per-cycle comparison of DUT outputs against the model timeline.
  always @(negedge CLK) begin
    if (cmp_on) begin
      if (cyc < exp_n) begin
        chk("pc",     32'(pc),     32'(x_pc[cyc]));
        chk("ac",     32'(ac),     32'(x_ac[cyc]));
        chk("e",      32'(e),      32'(x_e[cyc]));
        chk("halted", 32'(halted), 32'(x_h[cyc]));
        chk("zero",   32'(zero),   32'(x_ac[cyc] == 8'd0));
      end
      cyc++;
    end
  end

  task automatic reset_dut();
    RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    m_pc = '0; m_ac = '0; m_e = 1'b0;
  endtask

  task automatic load(input int a, input logic [7:0] d);
    @(posedge CLK); #1 ld_addr = 4'(a); ld_data = d; ld_we = 1'b1;
    @(posedge CLK); #1 ld_we = 1'b0;
    mm[a] = d;
  endtask

  task automatic peek(input int a, output logic [7:0] d);
    ld_addr = 4'(a);
    #1 d = ld_rdata;
  endtask

  // Start a run; hcyc is the cycle index (T0 = 0) at which halted is first seen high.
  task automatic run_prog(input int max_instr, input bit poke, output int hcyc);
    model_run(max_instr);
    hcyc = -1;
    @(posedge CLK); #1 start = 1'b1;
    @(posedge CLK); #1 start = 1'b0; cyc = 0; cmp_on = 1'b1;
    for (int k = 0; k < exp_n; k++) begin
      @(negedge CLK);
      if (halted && hcyc < 0) hcyc = k;
      if (poke) begin
        ld_we = (k == 1 || k == 4);
        ld_addr = '0;
        ld_data = 8'hFF;
      end
    end
    #1 cmp_on = 1'b0; ld_we = 1'b0;
    if (!m_done) begin
      @(posedge CLK); #1 reset_dut();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    int hc;
    for (int a = 0; a < 16; a++) mm[a] = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_halted", 32'(halted), 1);
    chk("rst_pc",     32'(pc),     0);
    chk("rst_ac",     32'(ac),     0);
    chk("rst_e",      32'(e),      0);
    chk("rst_zero",   32'(zero),   1);
    RST = 1'b0;
    for (int a = 0; a < 16; a++) load(a, 8'h00);

    // Program run: LDA 8, ADD 9, STA 10, HLT.
    load(0, 8'h48); load(1, 8'h09); load(2, 8'h5A); load(3, 8'h70);
    load(8, 8'h05); load(9, 8'h03);
    run_prog(20, 1'b0, hc);
    chk("prog_halt_cyc", 32'(hc), 21);
    chk("prog_ac", 32'(ac), 'h08);
    chk("prog_e",  32'(e),  0);
    chk("prog_pc", 32'(pc), 4);
    peek(10, d);
    chk("prog_m10", 32'(d), 'h08);

    // Indirect LDA through M8.
    reset_dut();
    load(0, 8'hC8); load(1, 8'h70); load(8, 8'h0C); load(12, 8'hA5);
    run_prog(20, 1'b0, hc);
`ifdef CPU_INDIRECT_EN
    chk("ind_ac", 32'(ac), 'hA5);
    chk("ind_len", 32'(hc), 12);
`else
    chk("ind_ac", 32'(ac), 'h0C);
    chk("ind_len", 32'(hc), 10);
`endif

    // SUB with borrow.
    reset_dut();
    load(0, 8'h48); load(1, 8'h19); load(2, 8'h70); load(8, 8'h03); load(9, 8'h05);
    run_prog(20, 1'b0, hc);
    chk("sub_ac", 32'(ac), 'hFE);
    chk("sub_e",  32'(e),  0);

    // SHL carry-out.
    reset_dut();
    load(1, 8'h30); load(8, 8'h81);
    run_prog(20, 1'b0, hc);
    chk("shl_ac", 32'(ac), 'h02);
    chk("shl_e",  32'(e),  1);
    chk("shl_pc", 32'(pc), 3);

    // CMA keeps E from the previous run.
    load(3, 8'h49); load(4, 8'h60); load(5, 8'h70); load(9, 8'h0F);
    run_prog(20, 1'b0, hc);
    chk("cma_ac", 32'(ac), 'hF0);
    chk("cma_e",  32'(e),  1);

    // PC wrap from 15 to 0.
    reset_dut();
    for (int a = 0; a < 14; a++) load(a, 8'h60);
    load(14, 8'h70);
    run_prog(30, 1'b0, hc);
    chk("wrap_pc15", 32'(pc), 15);
    load(15, 8'h30); load(0, 8'h70);
    run_prog(20, 1'b0, hc);
    chk("wrap_pc1", 32'(pc), 1);

    // Reset during EX0 of STA to M10.
    reset_dut();
    load(0, 8'h48); load(1, 8'h5A); load(2, 8'h70); load(8, 8'h77); load(10, 8'h00);
    @(posedge CLK); #1 start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    repeat (11) @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("rsta_halted", 32'(halted), 1);
    chk("rsta_pc",     32'(pc),     0);
    chk("rsta_ac",     32'(ac),     0);
    chk("rsta_zero",   32'(zero),   1);
    @(posedge CLK); #1;
    chk("rsta_halted2", 32'(halted), 1);
    chk("rsta_pc2",     32'(pc),     0);
    RST = 1'b0;
    m_pc = '0; m_ac = '0; m_e = 1'b0;
    peek(10, d);
    chk("rsta_m10", 32'(d), 'h00);

    // Host writes ignored while running.
    reset_dut();
    load(0, 8'h48); load(1, 8'h70); load(8, 8'h11);
    run_prog(20, 1'b1, hc);
    peek(0, d);
    chk("lock_m0", 32'(d), 'h48);
    chk("lock_ac", 32'(ac), 'h11);
    load(5, 8'h3C);
    peek(5, d);
    chk("lock_m5", 32'(d), 'h3C);

    // Random programs over the full memory.
    for (int r = 0; r < 8; r++) begin
      reset_dut();
      for (int a = 0; a < 16; a++) load(a, 8'($urandom));
      run_prog(60, 1'b0, hc);
      for (int a = 0; a < 16; a++) begin
        peek(a, d);
        chk("rand_mem", 32'(d), 32'(mm[a]));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
